// File: rtl/scalar_multiply_seq_if.sv
// Handshake and operand/result bundle for scalar_multiply_seq.
// The master issues requests; the slave (the multiplier) returns busy/done and results.
interface scalar_multiply_seq_if #(
  parameter int N_ELEM = 4
);
  logic                    start;
  logic [N_ELEM-1:0][31:0] vector1;
  logic signed [31:0]      scalar;
  logic                    busy;
  logic                    done;
  logic [N_ELEM-1:0][31:0] out;

  modport master (
    output start, vector1, scalar,
    input  busy, done, out
  );

  modport slave (
    input  start, vector1, scalar,
    output busy, done, out
  );
endinterface

// File: rtl/scalar_multiply_seq.sv
// Sequential element-wise vector * scalar: one signed 32x32 multiply per clock,
// start/busy/done handshake, result vector held until the next accepted start.
module scalar_multiply_seq #(
  parameter int N_ELEM   = 4,
  parameter bit SATURATE = 1'b0
) (
  input logic                  clk,
  input logic                  reset,
  scalar_multiply_seq_if.slave bus
);

  localparam int            IW   = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_ELEM - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q;
  logic [N_ELEM-1:0][31:0] vec_q;
  logic signed [31:0]      scal_q;
  logic [N_ELEM-1:0][31:0] out_q;

  logic signed [63:0]      op_a, op_b, prod;
  logic [31:0]             res;

  // Full-width signed product; both operands sign-extended so the low 64 bits are exact.
  always_comb begin
    op_a = {{32{vec_q[idx_q][31]}}, vec_q[idx_q]};
    op_b = {{32{scal_q[31]}}, scal_q};
    prod = op_a * op_b;
    res  = prod[31:0];
    if (SATURATE) begin
      if (prod > 64'sh0000_0000_7FFF_FFFF)
        res = 32'h7FFF_FFFF;
      else if (prod < -64'sh0000_0000_8000_0000)
        res = 32'h8000_0000;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (idx_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the result and snapshot arrays are reset explicitly because an aborted run must read back as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      vec_q  <= '0;
      scal_q <= '0;
      out_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            vec_q  <= bus.vector1;
            scal_q <= bus.scalar;
            out_q  <= '0;
            idx_q  <= '0;
          end
        end
        RUN: begin
          out_q[idx_q] <= res;
          idx_q        <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.out  = out_q;

endmodule

// File: tb/tb_scalar_multiply_seq.sv
// Directed bench for scalar_multiply_seq: a wrapping and a saturating instance
// receive identical stimulus and are checked against hand-computed vectors.
module tb_scalar_multiply_seq;

  localparam int N = 4;
  typedef logic [N-1:0][31:0] vec_t;

  logic clk;
  logic reset;
  int   n_asserts = 0;
  int   n_fails   = 0;

  scalar_multiply_seq_if #(.N_ELEM(N)) if0 ();
  scalar_multiply_seq_if #(.N_ELEM(N)) if1 ();

  scalar_multiply_seq #(.N_ELEM(N), .SATURATE(1'b0)) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  scalar_multiply_seq #(.N_ELEM(N), .SATURATE(1'b1)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic vec_t mk(input int a, input int b, input int c, input int d);
    vec_t v;
    v[0] = a;
    v[1] = b;
    v[2] = c;
    v[3] = d;
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic [31:0] s, input logic st);
    if0.vector1 = v;
    if0.scalar  = s;
    if0.start   = st;
    if1.vector1 = v;
    if1.scalar  = s;
    if1.start   = st;
  endtask

  task automatic set_start(input logic st);
    if0.start = st;
    if1.start = st;
  endtask

  task automatic check_flags(input string tag, input logic exp_busy, input logic exp_done);
    check({tag, " wrap busy"}, 32'(if0.busy), 32'(exp_busy));
    check({tag, " wrap done"}, 32'(if0.done), 32'(exp_done));
    check({tag, " sat busy"},  32'(if1.busy), 32'(exp_busy));
    check({tag, " sat done"},  32'(if1.done), 32'(exp_done));
  endtask

  task automatic check_vec(input string tag, input vec_t e0, input vec_t e1);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s wrap out[%0d]", tag, i), if0.out[i], e0[i]);
      check($sformatf("%s sat out[%0d]", tag, i),  if1.out[i], e1[i]);
    end
  endtask

  // One full transaction; with disturb set, inputs are scrambled and start is
  // held high through RUN and DONE, which must have no effect.
  task automatic run_vec(input string tag, input vec_t v, input logic [31:0] s,
                         input vec_t e0, input vec_t e1, input bit disturb);
    vec_t junk;
    drive(v, s, 1'b1);
    step();
    set_start(disturb);
    for (int k = 0; k < N; k++) begin
      check_flags({tag, " run"}, 1'b1, 1'b0);
      if (k == 0) begin
        check({tag, " wrap cleared"}, if0.out[N-1], 32'h0);
        check({tag, " sat cleared"},  if1.out[N-1], 32'h0);
      end
      if (disturb) begin
        junk = {$urandom(), $urandom(), $urandom(), $urandom()};
        drive(junk, $urandom(), 1'b1);
      end
      step();
    end
    check_flags({tag, " done"}, 1'b0, 1'b1);
    check_vec({tag, " result"}, e0, e1);
    step();
    set_start(1'b0);
    check_flags({tag, " after"}, 1'b0, 1'b0);
    check_vec({tag, " hold"}, e0, e1);
    if (disturb) begin
      for (int k = 0; k < 3; k++) begin
        step();
        check_flags({tag, " no redo"}, 1'b0, 1'b0);
      end
    end
  endtask

  vec_t b2b_v  [3];
  logic [31:0] b2b_s [3];
  vec_t b2b_e0 [3];
  vec_t b2b_e1 [3];

  initial begin
    // Reset held two cycles with start asserted.
    reset = 1'b1;
    drive(mk(9, 9, 9, 9), 32'd3, 1'b1);
    step();
    step();
    check_flags("reset", 1'b0, 1'b0);
    check_vec("reset", '0, '0);
    reset = 1'b0;
    set_start(1'b0);
    step();
    check_flags("post reset idle", 1'b0, 1'b0);

    // Basic run.
    run_vec("basic", mk(1, -2, 3, 0), 32'd5,
            mk(5, -10, 15, 0), mk(5, -10, 15, 0), 1'b0);

    // Overflow with scalar 4: 2^32, -4, (2^31-1)*4, -2^32.
    run_vec("ovf x4", mk(32'h4000_0000, -1, 32'h7FFF_FFFF, 32'hC000_0000), 32'd4,
            mk(0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0),
            mk(32'h7FFF_FFFF, 32'hFFFF_FFFC, 32'h7FFF_FFFF, 32'h8000_0000), 1'b0);

    // Overflow with scalar -1: INT_MIN * -1.
    run_vec("ovf x-1", mk(32'h8000_0000, 32'h7FFF_FFFF, 0, 1), 32'hFFFF_FFFF,
            mk(32'h8000_0000, 32'h8000_0001, 0, -1),
            mk(32'h7FFF_FFFF, 32'h8000_0001, 0, -1), 1'b0);

    // Input isolation: operands scrambled and start pulsed during RUN/DONE.
    run_vec("isolate", mk(6, -7, 8, 100), 32'd11,
            mk(66, -77, 88, 1100), mk(66, -77, 88, 1100), 1'b1);

    // Abort at idx 2 by reset, then restart with scalar -3.
    drive(mk(7, 7, 7, 7), 32'd2, 1'b1);
    step();
    set_start(1'b0);
    step();
    step();
    check("abort wrap partial", if0.out[0], 32'd14);
    check("abort sat partial",  if1.out[0], 32'd14);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_flags("abort", 1'b0, 1'b0);
    check_vec("abort", '0, '0);
    for (int k = 0; k < N + 2; k++) begin
      step();
      check_flags("abort quiet", 1'b0, 1'b0);
    end
    run_vec("restart", mk(1, -2, 100, 32'h8000_0000), 32'hFFFF_FFFD,
            mk(-3, 6, -300, 32'h8000_0000),
            mk(-3, 6, -300, 32'h7FFF_FFFF), 1'b0);

    // Back-to-back with start held high; operands change right after each acceptance.
    b2b_v[0]  = mk(2, 3, 4, 5);           b2b_s[0] = 32'd3;
    b2b_e0[0] = mk(6, 9, 12, 15);         b2b_e1[0] = b2b_e0[0];
    b2b_v[1]  = mk(-1, -1, 10, 0);        b2b_s[1] = 32'hFFFF_FFF9;
    b2b_e0[1] = mk(7, 7, -70, 0);         b2b_e1[1] = b2b_e0[1];
    b2b_v[2]  = mk(32'h1_0000, 32'h8000, -32'sh1_0000, 3); b2b_s[2] = 32'h1_0000;
    b2b_e0[2] = mk(0, 32'h8000_0000, 0, 32'h3_0000);
    b2b_e1[2] = mk(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h3_0000);

    drive(b2b_v[0], b2b_s[0], 1'b1);
    step();
    for (int s = 0; s < 3; s++) begin
      if (s < 2) drive(b2b_v[s+1], b2b_s[s+1], 1'b1);
      else       drive(mk(-5, -5, -5, -5), 32'd9, 1'b0);
      for (int k = 0; k < N; k++) begin
        check_flags($sformatf("b2b%0d run", s), 1'b1, 1'b0);
        step();
      end
      check_flags($sformatf("b2b%0d done", s), 1'b0, 1'b1);
      check_vec($sformatf("b2b%0d result", s), b2b_e0[s], b2b_e1[s]);
      step();
      check_flags($sformatf("b2b%0d idle", s), 1'b0, 1'b0);
      step();
    end
    check_flags("b2b end", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
